// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped seg/led/switch/button peripheral with debounce, edge irq and 7-seg scan
module mmio_periph #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFFF000,
  parameter int LED_W = 16,
  parameter int SW_W = 2,
  parameter int BTN_N = 5,
  parameter int DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              iow,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  output logic [DIGITS-1:0] seg_an,
  output logic [3:0]        seg_nib,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_N-1:0]  btn,
  output logic              irq
);
  localparam int CW = $clog2(DEB_CYC);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [31:0] seg_r, rmux;
  logic [BTN_N-1:0] mask, btn_edge, deb, btn_s1, btn_s2, rise, clr;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [CW-1:0] cnt [BTN_N];
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic hit, wr, rd;
  logic [5:0] off;
  assign hit = ce && addr[31:8] == BASE_ADDR[31:8] && addr[1:0] == 2'b00;
  assign wr = hit & iow;
  assign rd = hit & ~iow;
  assign off = addr[7:2];
  assign clr = (wr && off == 6'd4) ? wdata[BTN_N-1:0] : '0;
  assign seg_an = ~(DIGITS'(1) << idx);
  assign seg_nib = seg_r[{idx, 2'b00} +: 4];
  // read mux, zero for misses and unmapped offsets
  always_comb
    rmux = !rd ? 32'd0 :
           off == 6'd0 ? seg_r :
           off == 6'd1 ? 32'(led) :
           off == 6'd2 ? 32'(sw_s2) :
           off == 6'd3 ? 32'(deb) :
           off == 6'd4 ? 32'(btn_edge) :
           off == 6'd5 ? 32'(mask) : 32'd0;
  // debounced rising edge fires in the same cycle deb goes high
  always_comb begin
    rise = '0;
    for (int i = 0; i < BTN_N; i++)
      rise[i] = btn_s2[i] & ~deb[i] & (cnt[i] == CW'(DEB_CYC - 1));
  end
  // bus registers, edge capture (set beats clear) and irq
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg_r <= '0;
      led <= '0;
      mask <= '0;
      btn_edge <= '0;
      rdata <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && off == 6'd0) seg_r <= wdata;
      if (wr && off == 6'd1) led <= wdata[LED_W-1:0];
      if (wr && off == 6'd5) mask <= wdata[BTN_N-1:0];
      btn_edge <= (btn_edge & ~clr) | rise;
      rdata <= rmux;
      irq <= |(btn_edge & mask);
    end
  // input synchronisers and per-button debounce counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      deb <= '0;
      for (int i = 0; i < BTN_N; i++) cnt[i] <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      for (int i = 0; i < BTN_N; i++)
        if (btn_s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEB_CYC - 1)) begin
          deb[i] <= btn_s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
    end
  // digit scan divider and index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
    end else div <= div + DW'(1);
endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: directed self-checking bench for mmio_periph
module tb_mmio_periph;
  localparam logic [31:0] BASE = 32'hFFFFF000;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, iow = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [15:0] led;
  logic [7:0] seg_an;
  logic [3:0] seg_nib;
  logic [1:0] sw = '0;
  logic [4:0] btn = '0;
  logic irq;
  int checks = 0, failures = 0;

  mmio_periph #(.SCAN_DIV(4), .DEB_CYC(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .iow(iow), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .seg_an(seg_an), .seg_nib(seg_nib),
    .sw(sw), .btn(btn), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1'b1; iow = 1'b1; addr = a; wdata = d;
    tick();
    ce = 1'b0; iow = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; iow = 1'b0; addr = a;
    tick();
    d = rdata;
    ce = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rd(BASE + 32'(4 * i), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL reset_read off=%0h got=%h exp=0", 4 * i, d);
      end
    end
    wr(BASE + 32'h04, 32'h1234);
    btn = 5'b00001;
    tick(7);
    rd(BASE + 32'h04, d);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (led !== 16'h0 || seg_an !== 8'hFE || seg_nib !== 4'h0 || rdata !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL async_reset led=%h an=%h nib=%h rdata=%h irq=%b exp 0/fe/0/0/0", led, seg_an, seg_nib, rdata, irq);
    end
    tick();
    rst = 1'b0;
    btn = '0;
    tick(15);
    rd(BASE + 32'h10, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL reset_no_edge got=%h exp=0", d);
    end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    do_reset();
    wr(BASE, 32'h76543210);
    wr(BASE + 32'h04, 32'hFFFFABCD);
    rd(BASE, d);
    checks++;
    if (d !== 32'h76543210) begin
      failures++;
      $display("FAIL seg_read got=%h exp=76543210", d);
    end
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'h0000ABCD || led !== 16'hABCD) begin
      failures++;
      $display("FAIL led_read got=%h led=%h exp=0000abcd", d, led);
    end
    wr(BASE + 32'h04, 32'h5555);
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'h5555) begin
      failures++;
      $display("FAIL wr_rd_b2b got=%h exp=5555", d);
    end
    wr(BASE + 32'h05, 32'h9999);
    wr(32'hFFFFE004, 32'h7777);
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'h5555) begin
      failures++;
      $display("FAIL bad_write_ignored got=%h exp=5555", d);
    end
    rd(BASE + 32'h18, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_read got=%h exp=0", d);
    end
    rd(BASE + 32'h01, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL misaligned_read got=%h exp=0", d);
    end
    wr(BASE + 32'h14, 32'hFFFFFFFF);
    rd(BASE + 32'h14, d);
    checks++;
    if (d !== 32'h1F) begin
      failures++;
      $display("FAIL mask_width got=%h exp=1f", d);
    end
  endtask

  task automatic test_scan;
    int bad;
    logic [7:0] ea;
    do_reset();
    wr(BASE, 32'h76543210);
    bad = 0;
    for (int e = 1; e <= 70; e++) begin
      ea = ~(8'h01 << ((e / 4) % 8));
      if (seg_an !== ea || seg_nib !== 4'((e / 4) % 8)) begin
        bad++;
        if (bad < 4) $display("FAIL scan e=%0d an=%h nib=%h exp=%h/%0d", e, seg_an, seg_nib, ea, (e / 4) % 8);
      end
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    wr(BASE, 32'hFFFFFFFF);
    checks++;
    if (seg_nib !== 4'hF) begin
      failures++;
      $display("FAIL seg_live got=%h exp=f", seg_nib);
    end
  endtask

  task automatic test_debounce;
    logic [31:0] d;
    do_reset();
    btn = 5'b00001;
    tick(5);
    btn = '0;
    tick(14);
    rd(BASE + 32'h0C, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL glitch_level got=%h exp=0", d);
    end
    rd(BASE + 32'h10, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL glitch_edge got=%h exp=0", d);
    end
    btn = 5'b00001;
    tick(9);
    rd(BASE + 32'h0C, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL deb_early got=%h exp=0", d);
    end
    rd(BASE + 32'h0C, d);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL deb_level got=%h exp=1", d);
    end
    rd(BASE + 32'h10, d);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL deb_edge got=%h exp=1", d);
    end
    btn = '0;
    tick(12);
    wr(BASE + 32'h10, 32'h1);
    rd(BASE + 32'h10, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL w1c got=%h exp=0", d);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    do_reset();
    wr(BASE + 32'h14, 32'h1);
    btn = 5'b00001;
    tick(10);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_early got=%b exp=0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set got=%b exp=1", irq);
    end
    wr(BASE + 32'h10, 32'h1);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got=%b exp=0", irq);
    end
    btn = '0;
    tick(12);
    btn = 5'b00001;
    tick(9);
    wr(BASE + 32'h10, 32'h1);
    rd(BASE + 32'h10, d);
    checks++;
    if (d !== 32'd1 || irq !== 1'b1) begin
      failures++;
      $display("FAIL set_beats_clr edge=%h irq=%b exp=1/1", d, irq);
    end
    wr(BASE + 32'h14, 32'h0);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_masked got=%b exp=0", irq);
    end
    btn = '0;
  endtask

  task automatic test_sw;
    logic [31:0] d;
    do_reset();
    sw = 2'b10;
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL sw_sync1 got=%h exp=0", d);
    end
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL sw_sync2 got=%h exp=0", d);
    end
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'd2) begin
      failures++;
      $display("FAIL sw_read got=%h exp=2", d);
    end
    wr(BASE + 32'h08, 32'hFFFFFFFF);
    wr(BASE + 32'h0C, 32'hFFFFFFFF);
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'd2) begin
      failures++;
      $display("FAIL sw_ro got=%h exp=2", d);
    end
    rd(BASE + 32'h0C, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL btn_ro got=%h exp=0", d);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_scan();
    test_debounce();
    test_irq();
    test_sw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
